// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the datapath widths, the requester index map, the FSM state
// encoding and the round-robin pointer advance helper.
package regfile_wb_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 16;
  localparam int STAT_W  = 2;
  localparam int BANK_W  = 6;
  localparam int PTR_W   = 2;

  localparam int REQ_ARITH_A = 0;
  localparam int REQ_ARITH_B = 1;
  localparam int REQ_LS_A    = 2;
  localparam int REQ_LS_B    = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } arb_state_e;

  // Index of the requester just after idx, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) begin
      return {PTR_W{1'b0}};
    end else begin
      return idx + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_dual_grant.sv
// Combinational round-robin dual grant selector.
// Scans requesters starting at rr_ptr; the first valid one wins port A,
// the next valid one with a different address wins port B.
// Ports: valid/addr (packed per requester), rr_ptr in; one-hot grants,
// grant indices and found flags out.
module regfile_wb_arbiter_rr_dual_grant
  import regfile_wb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]        valid,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [PTR_W-1:0]          rr_ptr,
  output logic [NUM_REQ-1:0]        grant_a,
  output logic [NUM_REQ-1:0]        grant_b,
  output logic [PTR_W-1:0]          idx_a,
  output logic [PTR_W-1:0]          idx_b,
  output logic                      found_a,
  output logic                      found_b
);

  int                scan_s;
  logic [PTR_W-1:0]  pos_s;
  logic [ADDR_W-1:0] addr_a_s;
  logic [ADDR_W-1:0] addr_cur_s;

  // Rotating priority scan producing up to two non-colliding grants.
  always_comb begin
    grant_a    = {NUM_REQ{1'b0}};
    grant_b    = {NUM_REQ{1'b0}};
    idx_a      = {PTR_W{1'b0}};
    idx_b      = {PTR_W{1'b0}};
    found_a    = 1'b0;
    found_b    = 1'b0;
    addr_a_s   = {ADDR_W{1'b0}};
    scan_s     = 0;
    pos_s      = {PTR_W{1'b0}};
    addr_cur_s = {ADDR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_s     = (int'(rr_ptr) + k) % NUM_REQ;
      pos_s      = PTR_W'(scan_s);
      addr_cur_s = addr[int'(pos_s)*ADDR_W +: ADDR_W];
      if (valid[pos_s]) begin
        if (!found_a) begin
          found_a        = 1'b1;
          idx_a          = pos_s;
          grant_a[pos_s] = 1'b1;
          addr_a_s       = addr_cur_s;
        end else if (!found_b && (addr_cur_s != addr_a_s)) begin
          // Same-address requesters are skipped so both ports never collide.
          found_b        = 1'b1;
          idx_b          = pos_s;
          grant_b[pos_s] = 1'b1;
        end else begin
        end
      end else begin
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges NUM_REQ writeback requesters onto
// two write ports (round-robin, no same-address pair) and sequences bank
// select changes by draining in-flight writes first.
// Ports: clock_i/reset_i (async active-low); req_* valid/ready handshake with
// packed addr/data/status; wr_a_*/wr_b_* registered write ports; bank_req_i/
// bank_sel_i request a bank change, acknowledged by bank_ack_o as
// bank_select_o updates; busy_o flags pending work.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*STAT_W-1:0] req_status_i,
  input  logic [NUM_REQ-1:0]        req_stat_en_i,
  output logic                      wr_a_en_o,
  output logic [ADDR_W-1:0]         wr_a_addr_o,
  output logic [DATA_W-1:0]         wr_a_data_o,
  output logic [STAT_W-1:0]         wr_a_stat_o,
  output logic                      wr_a_stat_en_o,
  output logic                      wr_b_en_o,
  output logic [ADDR_W-1:0]         wr_b_addr_o,
  output logic [DATA_W-1:0]         wr_b_data_o,
  output logic [STAT_W-1:0]         wr_b_stat_o,
  output logic                      wr_b_stat_en_o,
  input  logic                      bank_req_i,
  input  logic [BANK_W-1:0]         bank_sel_i,
  output logic                      bank_ack_o,
  output logic [BANK_W-1:0]         bank_select_o,
  output logic                      busy_o
);

  arb_state_e        state_r;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [NUM_REQ-1:0] grant_a_s;
  logic [NUM_REQ-1:0] grant_b_s;
  logic [PTR_W-1:0]  idx_a_s;
  logic [PTR_W-1:0]  idx_b_s;
  logic              found_a_s;
  logic              found_b_s;
  logic              run_s;
  logic              take_a_s;
  logic              take_b_s;

  regfile_wb_arbiter_rr_dual_grant u_grant (
    .valid   (req_valid_i),
    .addr    (req_addr_i),
    .rr_ptr  (rr_ptr_r),
    .grant_a (grant_a_s),
    .grant_b (grant_b_s),
    .idx_a   (idx_a_s),
    .idx_b   (idx_b_s),
    .found_a (found_a_s),
    .found_b (found_b_s)
  );

  // Grants are only issued while running; DRAIN and SWITCH hold everyone off.
  assign run_s       = (state_r == ST_RUN);
  assign take_a_s    = run_s && found_a_s;
  assign take_b_s    = run_s && found_b_s;
  assign req_ready_o = run_s ? (grant_a_s | grant_b_s) : {NUM_REQ{1'b0}};
  assign busy_o      = (!run_s) || wr_a_en_o || wr_b_en_o;

  // Write-port registers and round-robin pointer; idle ports keep their payload.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_a_en_o      <= 1'b0;
      wr_a_addr_o    <= {ADDR_W{1'b0}};
      wr_a_data_o    <= {DATA_W{1'b0}};
      wr_a_stat_o    <= {STAT_W{1'b0}};
      wr_a_stat_en_o <= 1'b0;
      wr_b_en_o      <= 1'b0;
      wr_b_addr_o    <= {ADDR_W{1'b0}};
      wr_b_data_o    <= {DATA_W{1'b0}};
      wr_b_stat_o    <= {STAT_W{1'b0}};
      wr_b_stat_en_o <= 1'b0;
      rr_ptr_r       <= {PTR_W{1'b0}};
    end else begin
      if (take_a_s) begin
        wr_a_en_o      <= 1'b1;
        wr_a_addr_o    <= req_addr_i[int'(idx_a_s)*ADDR_W +: ADDR_W];
        wr_a_data_o    <= req_data_i[int'(idx_a_s)*DATA_W +: DATA_W];
        wr_a_stat_o    <= req_status_i[int'(idx_a_s)*STAT_W +: STAT_W];
        wr_a_stat_en_o <= req_stat_en_i[idx_a_s];
      end else begin
        wr_a_en_o      <= 1'b0;
        wr_a_stat_en_o <= 1'b0;
      end
      if (take_b_s) begin
        wr_b_en_o      <= 1'b1;
        wr_b_addr_o    <= req_addr_i[int'(idx_b_s)*ADDR_W +: ADDR_W];
        wr_b_data_o    <= req_data_i[int'(idx_b_s)*DATA_W +: DATA_W];
        wr_b_stat_o    <= req_status_i[int'(idx_b_s)*STAT_W +: STAT_W];
        wr_b_stat_en_o <= req_stat_en_i[idx_b_s];
      end else begin
        wr_b_en_o      <= 1'b0;
        wr_b_stat_en_o <= 1'b0;
      end
      // Pointer moves past the last requester served this cycle.
      if (take_b_s) begin
        rr_ptr_r <= ptr_after(idx_b_s);
      end else if (take_a_s) begin
        rr_ptr_r <= ptr_after(idx_a_s);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Bank-change sequencer: RUN -> DRAIN (wait for write ports idle) -> SWITCH.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r       <= ST_RUN;
      bank_select_o <= {BANK_W{1'b0}};
      bank_ack_o    <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          bank_ack_o <= 1'b0;
          if (bank_req_i) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!bank_req_i) begin
            state_r    <= ST_RUN;
            bank_ack_o <= 1'b0;
          end else if (!wr_a_en_o && !wr_b_en_o) begin
            // Select and ack are registered together so ack marks the new bank.
            state_r       <= ST_SWITCH;
            bank_select_o <= bank_sel_i;
            bank_ack_o    <= 1'b1;
          end else begin
            state_r    <= ST_DRAIN;
            bank_ack_o <= 1'b0;
          end
        end
        ST_SWITCH: begin
          state_r    <= ST_RUN;
          bank_ack_o <= 1'b0;
        end
        default: begin
          state_r    <= ST_RUN;
          bank_ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates register-file writeback between NUM_REQ requesters (arith pipe A, arith pipe B, load/store A, load/store B) onto the register file's two write ports.
- Round-robin, up to two grants per cycle.
- Guarantees the two ports never target the same address in one cycle.
- Sequences bank-select changes: drains in-flight writes before updating the bank select.

Parameters:
NUM_REQ, 4, number of writeback requesters (index 0 = arith A, 1 = arith B, 2 = LS A, 3 = LS B)
ADDR_W, 5, register address width within a bank
DATA_W, 16, register data width
STAT_W, 2, operation status width (bit1 overflow, bit0 underflow)
BANK_W, 6, bank select width

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
req_valid_i  in  NUM_REQ  per-requester write request
req_ready_o  out  NUM_REQ  per-requester grant; a transfer occurs when valid and ready are both high
req_addr_i  in  NUM_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data_i  in  NUM_REQ*DATA_W  packed write data
req_status_i  in  NUM_REQ*STAT_W  packed op status (LS requesters tie 0)
req_stat_en_i  in  NUM_REQ  status-update flag per requester (1 for arith, 0 for LS)
wr_a_en_o / wr_b_en_o  out  1  write enable, port A/B
wr_a_addr_o / wr_b_addr_o  out  ADDR_W  write address
wr_a_data_o / wr_b_data_o  out  DATA_W  write data
wr_a_stat_o / wr_b_stat_o  out  STAT_W  status to latch
wr_a_stat_en_o / wr_b_stat_en_o  out  1  status-latch enable
bank_req_i  in  1  request bank change; held until ack
bank_sel_i  in  BANK_W  requested bank
bank_ack_o  out  1  one-cycle pulse when bank_select_o updates
bank_select_o  out  BANK_W  current bank to register file
busy_o  out  1  high whenever state != RUN or any wr_*_en_o is high

Behaviour:
- Reset (reset_i low, async): all outputs 0, rr_ptr 0, state RUN, bank_select_o 0. Pending output writes are dropped.
- req_ready_o is combinational from req_valid_i, rr_ptr and state. It is all-zero unless state is RUN.
- Grant selection in RUN:
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - First valid requester is granted port A.
  - Next valid requester whose address differs from port A's is granted port B.
  - Valid requesters whose address matches port A's get ready=0 and must hold their request.
- Latency: the granted request appears on wr_*_o on the next rising edge (registered, 1 cycle). Unused port has en=0; its addr/data/stat hold their previous values.
- rr_ptr update:
  - Two grants: rr_ptr <= (B index + 1) mod NUM_REQ.
  - One grant: rr_ptr <= (A index + 1) mod NUM_REQ.
  - No grant: unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ-1 cycles, except while blocked by an address collision.
- FSM states RUN, DRAIN, SWITCH:
  - RUN: bank_req_i=1 -> DRAIN. Grants are still issued in that same cycle.
  - DRAIN: no grants. Go to SWITCH when wr_a_en_o=0 and wr_b_en_o=0 (takes 1 cycle after last grant). If bank_req_i falls, return to RUN.
  - SWITCH: bank_select_o <= bank_sel_i, bank_ack_o=1 for this single cycle, -> RUN unconditionally. The requester must drop bank_req_i the cycle after ack.
- bank_req_i asserted with bank_sel_i == bank_select_o still runs the full sequence and acks.
- Reset mid-DRAIN/SWITCH: returns to RUN with bank_select_o=0 and no ack issued.

Decomposition:
- Shared package: STAT_W, ADDR_W, DATA_W, BANK_W constants; FSM state encoding (RUN=2'd0, DRAIN=2'd1, SWITCH=2'd2); requester index constants (REQ_ARITH_A … REQ_LS_B).
- One natural sub-module: rr_dual_grant. It is combinational; inputs are valid vector, addresses and rr_ptr; outputs are grant A/B one-hot vectors and indices.

Test Plan:
- Reset, then all four valid, addresses 1,2,3,4, rr_ptr=0 -> ready=0011. Next cycle: wr_a=(1,data0), wr_b=(2,data1). Then ready=1100; rr_ptr sequence 0->2->0.
- Requesters 0 and 1 both at address 7, req 2 at address 9 -> ready=0101; port A=addr 7 (req0), port B=addr 9 (req2). Req1 granted on port A the following cycle.
- Single valid req3 with status 2'b10, stat_en=1 -> wr_a_en=1, wr_a_stat_o=2'b10, wr_a_stat_en_o=1, wr_b_en=0, rr_ptr wraps to 0.
- bank_req_i=1, bank_sel_i=6'd3 during traffic -> ready=0 from next cycle; writes drain in 1 cycle; SWITCH cycle shows bank_ack_o=1 and bank_select_o=3; grants resume in the cycle after.
- bank_req_i dropped during DRAIN -> back to RUN, no ack, bank_select_o unchanged.
- reset_i pulsed low mid-SWITCH, asynchronous to the clock -> outputs 0 immediately, bank_select_o=0, state RUN on release.
